// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Register map and control-bit positions for multi_clock_divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam logic [1:0] REG_DIV   = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_SYNC  = 2'd3;

    localparam int EN_BIT  = 0;
    localparam int POL_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_channel
// Description : One divider channel: half-period counter, output phase, tick.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_channel #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] div,
    input  logic             en,
    input  logic             pol,
    input  logic             load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] w_term;
    logic [CNT_W-1:0] r_count;
    logic             r_phase;
    logic             r_tick;

    // Divisors 0 and 1 both mean "toggle every clk", so the terminal value never underflows.
    assign w_term = (div < CNT_W'(2)) ? '0 : div - CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
        end else if (sync || !en) begin
            r_count <= '0;
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
        end else if (load) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count == w_term) begin
            r_count <= '0;
            r_phase <= ~r_phase;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + CNT_W'(1);
            r_tick  <= 1'b0;
        end
    end

    // Polarity is applied outside the phase so a POL write inverts without disturbing the count.
    assign clk_out = r_phase ^ pol;
    assign tick    = r_tick;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider
// Description : Avalon-MM slave with NUM_CH programmable divided clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 25,
    parameter  int DIV_RESET = 6,
    parameter  int EN_RESET  = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [CH_W+1:0]   address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CH_W-1:0]   w_ch;
    logic [1:0]        w_reg;
    logic              w_wr;
    logic              w_rd;
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_sync;
    logic [31:0]       w_rdata;
    logic              w_unused;

    logic [CNT_W-1:0]  r_div   [NUM_CH];
    logic [CNT_W-1:0]  w_count [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_pol;

    assign w_ch     = address[CH_W+1:2];
    assign w_reg    = address[1:0];
    assign w_wr     = chipselect & write;
    assign w_rd     = chipselect & read;
    assign w_ch_ok  = (int'(w_ch) < NUM_CH);
    assign w_unused = ^writedata;

    // SYNC is honoured at any channel address; the mask selects the channels.
    assign w_sync = (w_wr && (w_reg == REG_SYNC)) ? writedata[NUM_CH-1:0] : '0;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_load[i] = w_wr && (w_reg == REG_DIV) && (w_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i] <= CNT_W'(DIV_RESET);
            end
            r_en  <= (EN_RESET != 0) ? '1 : '0;
            r_pol <= '0;
        end else if (w_wr && w_ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == CH_W'(i)) begin
                    if (w_reg == REG_DIV) begin
                        r_div[i] <= writedata[CNT_W-1:0];
                    end
                    if (w_reg == REG_CTRL) begin
                        r_en[i]  <= writedata[EN_BIT];
                        r_pol[i] <= writedata[POL_BIT];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                case (w_reg)
                    REG_DIV:   w_rdata = 32'(r_div[i]);
                    REG_CTRL: begin
                        w_rdata[EN_BIT]  = r_en[i];
                        w_rdata[POL_BIT] = r_pol[i];
                    end
                    REG_COUNT: w_rdata = 32'(w_count[i]);
                    default:   w_rdata = '0;
                endcase
            end
        end
    end

    // Reads sample pre-edge state, so a same-cycle write is seen only by the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (w_rd) begin
            readdata <= w_rdata;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .div     (r_div[i]),
            .en      (r_en[i]),
            .pol     (r_pol[i]),
            .load    (w_load[i]),
            .sync    (w_sync[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .count   (w_count[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_clock_divider
// Description : Directed plus random bench for multi_clock_divider with a closed-form model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 25;
    localparam int AW     = 5;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              chipselect = 1'b0;
    logic              read       = 1'b0;
    logic              write      = 1'b0;
    logic [AW-1:0]     address    = '0;
    logic [31:0]       writedata  = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Each channel is described by the edge at which its count last restarted at 0 (m_t0)
    // and the phase it held then; everything else follows by division and modulo.
    int          m_div [NUM_CH];
    bit          m_en  [NUM_CH];
    bit          m_pol [NUM_CH];
    bit          m_ph0 [NUM_CH];
    int          m_t0  [NUM_CH];
    logic [31:0] rd_exp = '0;

    multi_clock_divider #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DIV_RESET (6),
        .EN_RESET  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    function automatic int dv(input int c);
        return (m_div[c] < 2) ? 1 : m_div[c];
    endfunction

    function automatic bit ph_at(input int c, input int t);
        return m_ph0[c] ^ ((((t - m_t0[c]) / dv(c)) % 2) == 1);
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clk();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = ph_at(c, cyc) ^ m_pol[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++)
            v[c] = (cyc > m_t0[c]) && (((cyc - m_t0[c]) % dv(c)) == 0);
        return v;
    endfunction

    function automatic logic [31:0] rd_model(input int ch, input int rg);
        if (ch >= NUM_CH) return 32'h0;
        case (rg)
            0:       return 32'(m_div[ch]);
            1:       return {30'h0, m_pol[ch], m_en[ch]};
            2:       return 32'((cyc - m_t0[ch]) % dv(ch));
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c] = 6;
            m_en[c]  = 1'b1;
            m_pol[c] = 1'b0;
            m_ph0[c] = 1'b0;
            m_t0[c]  = cyc;
        end
        rd_exp = 32'h0;
    endtask

    task automatic model_edge(input int ach, input int arg);
        bit wr;
        wr = chipselect && write;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((wr && arg == 3 && writedata[c]) || !m_en[c]) begin
                m_t0[c]  = cyc;
                m_ph0[c] = 1'b0;
            end else if (wr && arg == 0 && ach == c) begin
                m_ph0[c] = ph_at(c, cyc - 1);
                m_t0[c]  = cyc;
            end
        end
        if (wr && ach < NUM_CH) begin
            if (arg == 0) m_div[ach] = int'(writedata[CNT_W-1:0]);
            if (arg == 1) begin
                m_en[ach]  = writedata[0];
                m_pol[ach] = writedata[1];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        int ach;
        int arg;
        ach = int'(address[4:2]);
        arg = int'(address[1:0]);
        if (reset_n && chipselect && read) rd_exp = rd_model(ach, arg);
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) model_reset();
        else          model_edge(ach, arg);
        check("clk_out",  32'(clk_out), 32'(exp_clk()));
        check("tick",     32'(tick),    32'(exp_tick()));
        check("readdata", readdata,     rd_exp);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic bus(input bit w, input bit r, input int ch, input int rg, input logic [31:0] d);
        chipselect = 1'b1;
        write      = w;
        read       = r;
        address    = AW'((ch << 2) | rg);
        writedata  = d;
        step();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
    endtask

    initial begin
        int ch, rg, sel;
        logic [31:0] d;

        // Reset and free-running default divide-by-12
        model_reset();
        run(3);
        check("reset_clk_out", 32'(clk_out), 32'h0);
        reset_n = 1'b1;
        run(5);
        check("first_half_low", 32'(clk_out), 32'h0);
        step();
        check("first_toggle_all", 32'(clk_out), 32'h1f);
        check("first_tick_all", 32'(tick), 32'h1f);
        run(20);

        // DIV write mid-count restarts the counter
        run($urandom_range(1, 4));
        bus(1'b1, 1'b0, 1, 0, 32'd3);
        check("div_write_no_tick", 32'(tick[1]), 32'h0);
        run(2);
        check("div_restart_wait", 32'(tick[1]), 32'h0);
        step();
        check("div_restart_tick", 32'(tick[1]), 32'h1);

        // Divisors 0 and 1 both toggle every clock
        bus(1'b1, 1'b0, 2, 0, 32'd0);
        run(5);
        bus(1'b1, 1'b0, 2, 0, 32'd1);
        run(5);

        // Disable, polarity, re-enable on ch3
        bus(1'b1, 1'b0, 3, 1, 32'h0);
        run(2);
        check("disabled_low", 32'(clk_out[3]), 32'h0);
        bus(1'b0, 1'b1, 3, 2, 32'h0);
        check("disabled_count", readdata, 32'h0);
        bus(1'b1, 1'b0, 3, 1, 32'h2);
        check("pol_high", 32'(clk_out[3]), 32'h1);
        bus(1'b1, 1'b0, 3, 1, 32'h3);
        run(5);
        check("reenable_hold", 32'(clk_out[3]), 32'h1);
        step();
        check("reenable_toggle", 32'(clk_out[3]), 32'h0);
        bus(1'b1, 1'b0, 3, 1, 32'h1);

        // Realign two channels with different divisors
        run($urandom_range(1, 7));
        bus(1'b1, 1'b0, 0, 0, 32'd4);
        run($urandom_range(1, 7));
        bus(1'b1, 1'b0, 1, 0, 32'd8);
        run($urandom_range(1, 7));
        bus(1'b1, 1'b0, 2, 3, 32'h3);
        check("sync_level", 32'(clk_out[1:0]), 32'h0);
        run(15);
        step();
        check("sync_align_level", 32'(clk_out[1:0]), 32'h0);
        check("sync_align_tick", 32'(tick[1:0]), 32'h3);

        // Back-to-back COUNT reads, unmapped channel, SYNC readback
        chipselect = 1'b1;
        read       = 1'b1;
        address    = AW'(2);
        run(5);
        chipselect = 1'b0;
        read       = 1'b0;
        bus(1'b0, 1'b1, 6, 0, 32'h0);
        check("unmapped_read", readdata, 32'h0);
        bus(1'b0, 1'b1, 1, 3, 32'h0);
        bus(1'b0, 1'b1, 1, 0, 32'h0);

        // Random register traffic, including simultaneous read/write
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                step();
            end else begin
                ch = $urandom_range(0, 7);
                rg = $urandom_range(0, 3);
                case (rg)
                    0:       d = 32'($urandom_range(0, 9));
                    1:       d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1) << 1 | 1);
                    3:       d = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 31)) : 32'h0;
                    default: d = $urandom;
                endcase
                chipselect = ($urandom_range(0, 9) != 0);
                write      = $urandom_range(0, 1);
                read       = $urandom_range(0, 1);
                address    = AW'((ch << 2) | rg);
                writedata  = d;
                step();
                chipselect = 1'b0;
                write      = 1'b0;
                read       = 1'b0;
            end
        end
        bus(1'b0, 1'b1, 0, 1, 32'h0);
        run(3);

        // Asynchronous reset mid-period
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_clk_out", 32'(clk_out), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_readdata", readdata, 32'h0);
        run(2);
        reset_n = 1'b1;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
